// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, active-low byte write masks and the LSU state encoding.
package cpu_pkg;

    localparam logic [5:0] OP_LW = 6'd16;
    localparam logic [5:0] OP_LH = 6'd18;
    localparam logic [5:0] OP_LB = 6'd20;
    localparam logic [5:0] OP_SW = 6'd24;
    localparam logic [5:0] OP_SH = 6'd26;
    localparam logic [5:0] OP_SB = 6'd28;

    localparam logic [3:0] WREN_WORD = 4'b0000;
    localparam logic [3:0] WREN_HALF = 4'b1100;
    localparam logic [3:0] WREN_BYTE = 4'b1110;
    localparam logic [3:0] WREN_NONE = 4'b1111;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_WAIT = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_t;

    function automatic logic is_load_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LB);
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// MEM-stage request/response bundle between the pipeline and the load/store unit.
interface dmem_lsu_if;
    logic        req;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wren;
    logic [31:0] rdata;
    logic        rvalid;
    logic        stall;
    logic        misalign_err;

    modport master (output req, op, addr, wdata, wren,
                    input  rdata, rvalid, stall, misalign_err);
    modport slave  (input  req, op, addr, wdata, wren,
                    output rdata, rvalid, stall, misalign_err);
endinterface

// File: rtl/dmem_bram.sv
// Word-organised data RAM with four byte lanes, per-lane write enable and registered read.
module dmem_bram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    logic [31:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: byte-lane stores, sign-extending loads, optional wait states.
// Optional misaligned-access trap enabled by defining LSU_ALIGN_TRAP_EN.
//
//   state | meaning
//   IDLE  | ready; accepts req
//   WAIT  | counting down WAIT_CYC wait cycles
//   DONE  | RAM access happened on entry; load result registered on exit
module dmem_lsu
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 0
) (
    input  logic       clk,
    input  logic       rst,
    dmem_lsu_if.slave  bus
);
    localparam logic [1:0] IDLE = LSU_IDLE;
    localparam logic [1:0] WAIT = LSU_WAIT;
    localparam logic [1:0] DONE = LSU_DONE;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYC > 0 ? WAIT_CYC - 1 : 0);

    logic [1:0]        state;
    logic [3:0]        wait_cnt;
    logic              store_q, load_q;
    logic [5:0]        op_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] widx_q;
    logic [3:0]        lanes_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              rvalid_q;

    logic              in_store, in_load, is_word, is_half, misaligned;
    logic              accept, go, fire_now, fire_wait;
    logic [1:0]        off_in;
    logic [3:0]        lanes_in;
    logic [31:0]       wdata_in;
    logic [ADDR_W-1:0] widx_in;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata, ram_q;
    logic [15:0]       ld_half;
    logic [7:0]        ld_byte;
    logic              unused_addr;

    assign in_store   = (bus.wren != WREN_NONE);
    assign in_load    = !in_store && is_load_op(bus.op);
    assign is_word    = in_store ? (bus.wren == WREN_WORD) : (bus.op == OP_LW);
    assign is_half    = in_store ? (bus.wren == WREN_HALF) : (bus.op == OP_LH);
    assign misaligned = (in_store || in_load) &&
                        ((is_word && (bus.addr[1:0] != 2'b00)) || (is_half && bus.addr[0]));
    // Without the trap, offending low bits are simply dropped.
    assign off_in     = !misaligned ? bus.addr[1:0] :
                        is_word     ? 2'b00 : {bus.addr[1], 1'b0};
    assign lanes_in   = (~bus.wren) << off_in;
    assign wdata_in   = bus.wdata << {off_in, 3'b000};
    assign widx_in    = bus.addr[ADDR_W+1:2];
    assign unused_addr = ^{bus.addr[31:ADDR_W+2]};

`ifdef LSU_ALIGN_TRAP_EN
    logic misalign_q;
    assign accept = bus.req && (state == IDLE) && !misalign_q;
    assign go     = accept && !misaligned;

    always_ff @(posedge clk) begin
        if (rst)                        misalign_q <= 1'b0;
        else if (accept && misaligned)  misalign_q <= 1'b1;
    end
    assign bus.misalign_err = misalign_q;
`else
    assign accept = bus.req && (state == IDLE);
    assign go     = accept;
    assign bus.misalign_err = 1'b0;
`endif

    // The RAM is touched on the edge that enters DONE, from either IDLE or WAIT.
    assign fire_now  = go && (WAIT_CYC == 0);
    assign fire_wait = (state == WAIT) && (wait_cnt == 4'd0);
    assign ram_en    = !rst && (fire_now || fire_wait);
    assign ram_we    = !ram_en   ? 4'b0000 :
                       fire_now  ? (in_store ? lanes_in : 4'b0000) :
                                   (store_q  ? lanes_q  : 4'b0000);
    assign ram_addr  = fire_now ? widx_in  : widx_q;
    assign ram_wdata = fire_now ? wdata_in : wdata_q;

    dmem_bram #(.ADDR_W(ADDR_W)) u_bram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    assign ld_half = off_q[1] ? ram_q[31:16] : ram_q[15:0];
    assign ld_byte = ram_q[8*off_q +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            store_q  <= 1'b0;
            load_q   <= 1'b0;
            op_q     <= 6'd0;
            off_q    <= 2'd0;
            widx_q   <= '0;
            lanes_q  <= 4'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    store_q  <= in_store;
                    load_q   <= in_load;
                    op_q     <= bus.op;
                    off_q    <= off_in;
                    widx_q   <= widx_in;
                    lanes_q  <= lanes_in;
                    wdata_q  <= wdata_in;
                    wait_cnt <= WAIT_LOAD;
                    state    <= (WAIT_CYC > 0) ? WAIT : DONE;
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) state <= DONE;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                DONE: begin
                    state <= IDLE;
                    if (load_q) begin
                        rvalid_q <= 1'b1;
                        case (op_q)
                            OP_LH:   rdata_q <= {{16{ld_half[15]}}, ld_half};
                            OP_LB:   rdata_q <= {{24{ld_byte[7]}}, ld_byte};
                            default: rdata_q <= ram_q;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stall  = (state != IDLE);
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Data-memory load/store unit at the memory end of the store byte-mask path.
- Consumes the 4-bit active-low byte write-enable mask produced during decode: 0000 = word, 1100 = halfword, 1110 = byte, 1111 = no write.
- Performs stores into an internal byte-lane RAM, and loads with sign extension.
- Supports optional wait states. Sits in the MEM stage and raises stall to the pipeline while an access is outstanding.

Parameters:
- ADDR_W, 10: word-address width; RAM depth is 2**ADDR_W 32-bit words.
- WAIT_CYC, 0: extra wait cycles per access (0..15).

Ports:
- clk  in  1  Single clock; all state on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- req  in  1  Access request; sampled only when stall=0.
- op  in  6  Opcode. 16=lw, 18=lh, 20=lb. Stores are identified by wren≠1111.
- addr  in  32  Byte address, little-endian.
- wdata  in  32  Store data, right-justified (byte in [7:0], half in [15:0]).
- wren  in  4  Active-low byte mask: 0000 word, 1100 half, 1110 byte, 1111 none.
- rdata  out  32  Sign-extended load result; valid when rvalid=1.
- rvalid  out  1  One-cycle pulse marking a completed load.
- stall  out  1  High while an accepted access has not completed.
- misalign_err  out  1  Misaligned access flag (see Optional Feature).

Behaviour:
- Reset: rdata=0, rvalid=0, stall=0, misalign_err=0, FSM=IDLE. RAM contents are not reset.
- Accept condition: req=1 and stall=0 and the FSM is in IDLE.
  - Latch op, addr, wdata, wren and the lane mask.
  - Access type: store if wren≠1111; load if op∈{16,18,20}; otherwise a no-op (no write, no rvalid).
- Lane mask:
  - Lanes enabled = (~wren) << addr[1:0], truncated to 4 bits.
  - Write data = wdata << (8*addr[1:0]).
- Load extraction:
  - lw returns the whole word.
  - lh returns word[16*addr[1]+:16], sign-extended.
  - lb returns word[8*addr[1:0]+:8], sign-extended.
- Alignment rules: lw/sw require addr[1:0]=0; lh/sh require addr[0]=0; lb/sb may use any address.
- FSM states: IDLE -> WAIT (if WAIT_CYC>0) -> DONE -> IDLE.
  - IDLE: on accept, go to WAIT if WAIT_CYC>0, else to DONE.
  - WAIT: count down WAIT_CYC cycles; stall=1.
  - DONE (one cycle): RAM write (stores) or RAM read (loads) occurs on entry.
  - rvalid=1 and rdata updated in the cycle after DONE, for loads only.
  - stall=1 from the cycle after accept through DONE.
- Latency:
  - WAIT_CYC=0: load accepted in cycle N gives rvalid in N+2; stall is high in N+1 only.
  - In general, rvalid comes WAIT_CYC+2 cycles after accept.
- rdata holds its value until the next load completes.
- A load following a store to the same word returns the post-store data; the store is fully committed before the next accept.
- req while stall=1 is ignored; the requester holds its signals.
- Address bits above ADDR_W+1 are ignored (the address wraps).
- Reset mid-access aborts the access and forces the FSM to IDLE.
  - A store already in DONE has committed.
  - A store still in WAIT is dropped.

Optional Feature:
- Macro: LSU_ALIGN_TRAP_EN.
- Defined:
  - A misaligned access writes nothing and produces no rvalid.
  - It sets misalign_err, which is sticky until rst.
  - While misalign_err=1, further requests are ignored and stall stays 0.
- Undefined:
  - misalign_err is tied to 0.
  - Offending low address bits are forced to 0 (half: addr[0]; word: addr[1:0]) and the access proceeds normally.

Decomposition:
- Shared package cpu_pkg holds:
  - Opcode constants OP_LW=16, OP_LH=18, OP_LB=20, OP_SW=24, OP_SH=26, OP_SB=28.
  - Mask constants WREN_WORD=4'b0000, WREN_HALF=4'b1100, WREN_BYTE=4'b1110, WREN_NONE=4'b1111.
  - FSM state enum lsu_state_t.
- One sub-module: dmem_bram.
  - 4 byte-lane synchronous RAM with per-lane write enable and a 1-cycle read.
  - Instantiated once; the FSM and extraction logic stay in dmem_lsu.

Test Plan:
1. WAIT_CYC=0:
   - sw addr=0x10 wdata=0xDEADBEEF; then lw addr=0x10 -> rvalid two cycles after the lw accept, rdata=0xDEADBEEF.
   - stall is high for exactly 1 cycle per access.
2. sb addr=0x13 wdata=0x80, then lb addr=0x13 -> rdata=0xFFFFFF80.
   - Afterwards, lw addr=0x10 -> 0x80ADBEEF.
3. sh addr=0x22 wdata=0x1234, then lh addr=0x22 -> 0x00001234.
   - lw addr=0x20 -> upper half is 0x1234, lower half unchanged.
4. WAIT_CYC=3:
   - lw accepted at cycle N -> stall high N+1..N+4, rvalid at N+5.
   - A req held during the stall is accepted only at N+5.
5. With LSU_ALIGN_TRAP_EN: lw addr=0x11 -> misalign_err=1 next cycle, no rvalid, RAM unchanged.
   - A subsequent sw is ignored until rst.
   - Without the macro: the same lw returns the word at 0x10.
6. rst asserted during WAIT of an sw to 0x30 -> afterwards lw 0x30 returns the old value.
   - All outputs are 0 in the cycle after rst.
